alu_cmd_sequencer: RTL and testbench

Byte-stream command controller for the 8-bit ALU datapath: replaces the three load push-buttons with a serial protocol. It takes received bytes in the order A, B, OP and drives the ALU operand and opcode registers. It returns the ALU result as one byte over a valid/ready handshake. It sits between the UART receiver/transmitter and the combinational `alu`, in place of the button-driven load logic.

---
 rtl/alu_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-stream A/B/OP command sequencer driving the ALU and returning one result byte
module alu_cmd_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int TIMEOUT    = 1000000,
  parameter int NB_TIMEOUT = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [2:0]         o_state,
  output logic               o_timeout,
  output logic               o_drop
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;

  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  logic [2:0]            state_q, state_d;
  logic [NB_DATA-1:0]    data_a_q, data_a_d;
  logic [NB_DATA-1:0]    data_b_q, data_b_d;
  logic [NB_OP-1:0]      op_q, op_d;
  logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  drop_q, drop_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

  logic in_partial;
  logic timeout_hit;

  // A partial command is abandoned only when the idle budget is spent and no byte rescues it
  assign in_partial  = (state_q == S_B) || (state_q == S_OP);
  assign timeout_hit = in_partial && !i_rx_valid && (cnt_q == CNT_LAST);

  // State and datapath registers; reset wins over everything, including an open handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: bytes advance A->B->OP, EXEC is a single settling cycle, SEND waits for ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:    if (i_rx_valid) state_d = S_B;
      S_B: begin
        if (i_rx_valid)       state_d = S_OP;
        else if (timeout_hit) state_d = S_A;
      end
      S_OP: begin
        if (i_rx_valid)       state_d = S_EXEC;
        else if (timeout_hit) state_d = S_A;
      end
      S_EXEC: state_d = S_SEND;
      S_SEND: if (i_tx_ready) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Register updates: operands only move on byte acceptance so the ALU inputs stay stable through SEND
  always_comb begin
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    timeout_d  = timeout_hit;
    drop_d     = i_rx_valid && ((state_q == S_EXEC) || (state_q == S_SEND));
    cnt_d      = '0;
    case (state_q)
      S_A: begin
        if (i_rx_valid) data_a_d = i_rx_data;
      end
      S_B: begin
        if (i_rx_valid)        data_b_d = i_rx_data;
        else if (!timeout_hit) cnt_d    = cnt_q + NB_TIMEOUT'(1);
      end
      S_OP: begin
        if (i_rx_valid)        op_d  = i_rx_data[NB_OP-1:0];
        else if (!timeout_hit) cnt_d = cnt_q + NB_TIMEOUT'(1);
      end
      S_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_valid_d = 1'b1;
      end
      S_SEND: begin
        if (i_tx_ready) tx_valid_d = 1'b0;
      end
      default: begin
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign o_state    = state_q;
  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_timeout  = timeout_q;
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a command-level reference model
module tb_alu_cmd_sequencer;

  localparam int NB_DATA    = 8;
  localparam int NB_OP      = 6;
  localparam int TIMEOUT    = 16;
  localparam int NB_TIMEOUT = 5;

  logic               clk;
  logic               rst;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_valid;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   op;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [2:0]         state;
  logic               timeout;
  logic               drop;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_count = 0;
  int timeout_count = 0;

  alu_cmd_sequencer #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT), .NB_TIMEOUT(NB_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_data_a(data_a), .o_data_b(data_b), .o_op(op),
    .i_alu_result(alu_result),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_state(state), .o_timeout(timeout), .o_drop(drop)
  );

  // ALU stub: plain 8-bit add of the two operands
  assign alu_result = data_a + data_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the command (how many bytes collected, or result pending)
  int         m_phase;
  bit         m_valid = 0;
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  bit         m_txv, m_to, m_drop;
  int         m_idle;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
      m_txv = 0; m_to = 0; m_drop = 0; m_idle = 0;
    end else if (m_valid) begin
      m_to   = 0;
      m_drop = 0;
      if (m_phase <= 2) begin
        if (rx_valid) begin
          if (m_phase == 0) m_a = rx_data;
          else if (m_phase == 1) m_b = rx_data;
          else m_op = rx_data[5:0];
          m_phase = m_phase + 1;
          m_idle = 0;
        end else if (m_phase > 0) begin
          m_idle = m_idle + 1;
          if (m_idle == TIMEOUT) begin
            m_phase = 0; m_idle = 0; m_to = 1;
          end
        end
      end else if (m_phase == 3) begin
        m_tx = m_a + m_b;
        m_txv = 1;
        m_phase = 4;
        m_drop = rx_valid;
      end else begin
        m_drop = rx_valid;
        if (tx_ready) begin
          m_txv = 0;
          m_phase = 0;
        end
      end
    end
  end

  // Every cycle after the first reset, all outputs must agree with the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("state",    state,    m_phase);
      check("data_a",   data_a,   m_a);
      check("data_b",   data_b,   m_b);
      check("op",       op,       m_op);
      check("tx_data",  tx_data,  m_tx);
      check("tx_valid", tx_valid, m_txv);
      check("timeout",  timeout,  m_to);
      check("drop",     drop,     m_drop);
      if (drop) drop_count++;
      if (timeout) timeout_count++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);

    // Basic command
    do_reset();
    check("lit_reset_state", state, 0);
    check("lit_reset_txv", tx_valid, 0);
    check("lit_reset_a", data_a, 0);
    tx_ready = 1'b1;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'hE1);
    check("lit_basic_op", op, 8'h21);
    check("lit_basic_exec", state, 3);
    check("lit_basic_txv_k", tx_valid, 0);
    @(negedge clk);
    check("lit_basic_txv_k1", tx_valid, 1);
    check("lit_basic_txd", tx_data, 8'h08);
    @(negedge clk);
    check("lit_basic_txv_k2", tx_valid, 0);
    check("lit_basic_state_k2", state, 0);

    // Back-pressure, back-to-back bytes, drop during SEND
    tx_ready = 1'b0;
    drop_count = 0;
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lit_bp_txv", tx_valid, 1);
      check("lit_bp_txd", tx_data, 8'h01);
      if (i == 3) begin
        rx_data = 8'h77; rx_valid = 1'b1;
      end
      if (i == 4) begin
        rx_valid = 1'b0;
        check("lit_bp_drop", drop, 1);
      end
    end
    check("lit_bp_drop_count", drop_count, 1);
    check("lit_bp_a_kept", data_a, 8'hFF);
    check("lit_bp_b_kept", data_b, 8'h02);
    tx_ready = 1'b1;
    @(negedge clk);
    check("lit_bp_done_state", state, 0);
    check("lit_bp_done_txv", tx_valid, 0);

    // Timeout after 16 idle cycles in S_B
    timeout_count = 0;
    send_byte(8'h10);
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("lit_to_early", timeout, 0);
    end
    @(negedge clk);
    check("lit_to_pulse", timeout, 1);
    check("lit_to_state", state, 0);
    check("lit_to_a_kept", data_a, 8'h10);
    @(negedge clk);
    check("lit_to_one_pulse", timeout_count, 1);

    // B byte in the 16th idle cycle rescues the command
    timeout_count = 0;
    send_byte(8'h20);
    for (int i = 1; i < TIMEOUT; i++) @(negedge clk);
    send_byte(8'h30);
    check("lit_rescue_state", state, 2);
    check("lit_rescue_b", data_b, 8'h30);
    check("lit_rescue_no_to", timeout_count, 0);
    send_byte(8'h00);
    @(negedge clk);
    check("lit_rescue_txd", tx_data, 8'h50);
    @(negedge clk);

    // Reset mid-command in S_OP
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("lit_mid_in_op", state, 2);
    do_reset();
    check("lit_mid_state", state, 0);
    check("lit_mid_a", data_a, 0);
    check("lit_mid_b", data_b, 0);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    check("lit_mid_result", tx_data, 8'h02);
    @(negedge clk);

    // Reset during SEND with valid high
    tx_ready = 1'b0;
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h00);
    @(negedge clk);
    check("lit_send_txv_before", tx_valid, 1);
    do_reset();
    check("lit_send_txv_after", tx_valid, 0);
    check("lit_send_state_after", state, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_send_no_hs", tx_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
